// File: rtl/sos_stage_scheduler_if.sv
// sos_stage_scheduler_if: sample, datapath and result handshake bundle for sos_stage_scheduler.
// BYPASS_STAGE_EN adds bypass_mask, sized by NO_SOS.
interface sos_stage_scheduler_if #(
   parameter int BW = 9,
   parameter int CA_W = 5
`ifdef BYPASS_STAGE_EN
   , parameter int NO_SOS = 4
`endif
);
   logic in_valid, in_ready;
   logic signed [BW-1:0] in_sample, dp_x, dp_result, out_sample;
   logic [3:0] stage_idx;
   logic [2:0] tap_idx;
   logic [CA_W-1:0] coef_addr;
   logic mac_clr, mac_en, state_we, out_valid, out_ready, busy;
`ifdef BYPASS_STAGE_EN
   logic [NO_SOS-1:0] bypass_mask;
`endif
   modport master (
      input in_valid, in_sample, dp_result, out_ready,
`ifdef BYPASS_STAGE_EN
      bypass_mask,
`endif
      output in_ready, dp_x, stage_idx, tap_idx, coef_addr, mac_clr, mac_en, state_we, out_valid, out_sample, busy
   );
   modport slave (
      output in_valid, in_sample, dp_result, out_ready,
`ifdef BYPASS_STAGE_EN
      bypass_mask,
`endif
      input in_ready, dp_x, stage_idx, tap_idx, coef_addr, mac_clr, mac_en, state_we, out_valid, out_sample, busy
   );
endinterface

// File: rtl/sos_stage_scheduler.sv
// sos_stage_scheduler: sequences NO_SOS biquad stages on one shared MAC (IDLE/MAC/WRITE/OUT).
// BYPASS_STAGE_EN adds a per-stage bypass_mask and a one-cycle SKIP state.
module sos_stage_scheduler #(
   parameter int BW = 9,
   parameter int NO_SOS = 4,
   parameter int MAC_CYCLES = 5,
   parameter int CA_W = 5
) (
   input logic CLK,
   input logic RESET,
   sos_stage_scheduler_if.master io
);
   typedef enum logic [2:0] {
      IDLE, MAC, WRITE, OUT
`ifdef BYPASS_STAGE_EN
      , SKIP
`endif
   } state_t;
   state_t state, state_nx, first_st, next_st;
   logic [3:0] stage_idx, stage_inc;
   logic [2:0] tap_idx;
   logic last_tap, last_stage;
   assign stage_inc = stage_idx + 4'd1;
   assign last_tap = tap_idx == 3'(MAC_CYCLES - 1);
   assign last_stage = stage_idx == 4'(NO_SOS - 1);
`ifdef BYPASS_STAGE_EN
   logic [NO_SOS-1:0] mask_q, mask_sh;
   assign mask_sh = mask_q >> stage_inc;
   assign first_st = io.bypass_mask[0] ? SKIP : MAC;
   assign next_st = mask_sh[0] ? SKIP : MAC;
`else
   assign first_st = MAC;
   assign next_st = MAC;
`endif
   always_ff @(posedge CLK)
      state <= !RESET ? IDLE : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (io.in_valid) state_nx = first_st;
         MAC: if (last_tap) state_nx = WRITE;
         OUT: if (io.out_ready) state_nx = IDLE;
         default: state_nx = last_stage ? OUT : next_st;
      endcase
   end
   // tap_idx wraps to 0 on the last tap, and stage_idx returns to 0 on output handoff,
   // so IDLE always starts a sample from stage 0, tap 0.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stage_idx <= '0;
         tap_idx <= '0;
         io.dp_x <= '0;
         io.out_sample <= '0;
`ifdef BYPASS_STAGE_EN
         mask_q <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               io.dp_x <= io.in_sample;
`ifdef BYPASS_STAGE_EN
               mask_q <= io.bypass_mask;
`endif
            end
            MAC: tap_idx <= last_tap ? 3'd0 : tap_idx + 3'd1;
            WRITE: begin
               io.dp_x <= io.dp_result;
               if (last_stage) io.out_sample <= io.dp_result;
               else stage_idx <= stage_inc;
            end
`ifdef BYPASS_STAGE_EN
            SKIP: begin
               if (last_stage) io.out_sample <= io.dp_x;
               else stage_idx <= stage_inc;
            end
`endif
            OUT: if (io.out_ready) stage_idx <= '0;
            default: ;
         endcase
      end
   end
   // Strobes are masked by RESET so nothing is written or accepted in a reset cycle.
   assign io.in_ready = state == IDLE && RESET;
   assign io.state_we = state == WRITE && RESET;
   assign io.busy = state != IDLE;
   assign io.mac_en = state == MAC;
   assign io.mac_clr = state == MAC && tap_idx == 3'd0;
   assign io.out_valid = state == OUT;
   assign io.stage_idx = stage_idx;
   assign io.tap_idx = tap_idx;
   assign io.coef_addr = state == MAC ? CA_W'(32'(stage_idx) * MAC_CYCLES + 32'(tap_idx)) : '0;
endmodule
